conv_mem_host: RTL and testbench

CONV_MEM_HOST -- requirements
Module: conv_mem_host

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_bank_ram.sv | 35 +++
 rtl/conv_mem_host.sv | 150 +++++++++++++++
 tb/tb_conv_mem_host.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the CONV5x5 memory host.
package conv_pkg;

  localparam int DW          = 13;       // pixel / result data width
  localparam int AW          = 12;       // address width of every memory port
  localparam int IMG_DEPTH   = 4096;     // image memory words
  localparam int L0_DEPTH    = 4096;     // Layer0 words
  localparam int L1_DEPTH    = 1024;     // Layer1 words
  localparam int TIMEOUT_DEF = 2000000;  // default run cycle limit
  localparam int RC_W        = 31;       // run cycle counter width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DONE,
    ST_TOUT
  } state_t;

endpackage

// File: rtl/conv_bank_ram.sv
// Single-port-write, registered-read RAM bank. Writes beyond DEPTH are
// dropped and reads beyond DEPTH return zero, so a shallow bank can sit on a
// wide address bus. A same-edge read and write of one word returns old data.
module conv_bank_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int DW    = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int IW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic          w_ok;
  logic          r_ok;

  assign w_ok = int'(waddr) < DEPTH;
  assign r_ok = int'(raddr) < DEPTH;

  // Memory write and registered read port.
  // NOTE: the array has no reset on purpose; contents survive rst and runs,
  // and a reset branch here would turn the RAM into a huge flop bank.
  always_ff @(posedge clk) begin
    if (we && w_ok) mem[waddr[IW-1:0]] <= wdata;
    if (re)         rdata <= r_ok ? mem[raddr[IW-1:0]] : '0;
  end

endmodule

// File: rtl/conv_mem_host.sv
// Memory host for the CONV5x5 accelerator: image memory, two result layers,
// start/ready/busy sequencing with a run-cycle watchdog, and host preload /
// readout ports that are locked out while the accelerator is active.
module conv_mem_host #(
  parameter int DW      = conv_pkg::DW,
  parameter int TIMEOUT = conv_pkg::TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   ready,
  input  logic                   busy,
  input  logic [conv_pkg::AW-1:0] iaddr,
  output logic [DW-1:0]          idata,
  input  logic                   cwr,
  input  logic [conv_pkg::AW-1:0] caddr_wr,
  input  logic [DW-1:0]          cdata_wr,
  input  logic                   crd,
  input  logic [conv_pkg::AW-1:0] caddr_rd,
  output logic [DW-1:0]          cdata_rd,
  input  logic                   csel,
  input  logic                   ld_en,
  input  logic [conv_pkg::AW-1:0] ld_addr,
  input  logic [DW-1:0]          ld_data,
  input  logic                   hrd_en,
  input  logic                   hrd_sel,
  input  logic [conv_pkg::AW-1:0] hrd_addr,
  output logic [DW-1:0]          hrd_data,
  output logic                   hrd_vld,
  input  logic                   start,
  output logic                   done,
  output logic                   timeout,
  output logic [1:0]             wr_seen,
  output logic [conv_pkg::RC_W-1:0] run_cycles
);

  import conv_pkg::*;

  state_t          state, state_n;
  logic [RC_W-1:0] rc_q;
  logic            timeout_q;
  logic [1:0]      seen_q;
  logic            start_ok, active, at_limit;

  assign start_ok = start && (state == ST_IDLE || state == ST_TOUT);
  assign active   = (state == ST_ARM) || (state == ST_RUN);
  // The counter reaches the limit on the same edge that enters TOUT.
  assign at_limit = rc_q >= RC_W'(TIMEOUT - 1);

  // Next-state logic for the run sequencer.
  // NOTE: combinational blocks use blocking '=' and assign a default first,
  // so every path drives state_n and no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = ST_ARM;
      ST_ARM:  if (at_limit) state_n = ST_TOUT;
               else if (busy) state_n = ST_RUN;
      ST_RUN:  if (at_limit) state_n = ST_TOUT;
               else if (!busy) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      ST_TOUT: if (start) state_n = ST_ARM;
      default: state_n = ST_IDLE;
    endcase
  end

  // State register, saturating run counter, sticky timeout and write flags.
  // NOTE: clocked blocks use non-blocking '<=' so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rc_q      <= '0;
      timeout_q <= 1'b0;
      seen_q    <= '0;
    end else begin
      state <= state_n;
      if (start_ok)                  rc_q <= '0;
      else if (active && rc_q != '1) rc_q <= rc_q + 1'b1;
      if (start_ok)                  timeout_q <= 1'b0;
      else if (state_n == ST_TOUT)   timeout_q <= 1'b1;
      seen_q <= (start_ok ? 2'b00 : seen_q) | (cwr ? (csel ? 2'b10 : 2'b01) : 2'b00);
    end
  end

  assign ready      = (state == ST_ARM);
  assign done       = (state == ST_DONE);
  assign timeout    = timeout_q;
  assign wr_seen    = seen_q;
  assign run_cycles = rc_q;

  // Memory port steering. The accelerator read (crd) owns a layer's read port;
  // a host read of the same bank in the same cycle is not honoured.
  logic          img_we, hrd_ok, l0_crd, l1_crd, l0_re, l1_re;
  logic [AW-1:0] l0_raddr, l1_raddr;
  logic [DW-1:0] img_rdata, l0_rdata, l1_rdata;

  assign img_we   = ld_en && !active;
  assign hrd_ok   = hrd_en && !active && !(crd && csel == hrd_sel);
  assign l0_crd   = crd && !csel;
  assign l1_crd   = crd && csel;
  assign l0_re    = l0_crd || (hrd_ok && !hrd_sel);
  assign l1_re    = l1_crd || (hrd_ok && hrd_sel);
  assign l0_raddr = l0_crd ? caddr_rd : hrd_addr;
  assign l1_raddr = l1_crd ? caddr_rd : hrd_addr;

  conv_bank_ram #(.DEPTH(IMG_DEPTH), .AW(AW), .DW(DW)) u_img (
    .clk(clk), .we(img_we), .waddr(ld_addr), .wdata(ld_data),
    .re(state == ST_RUN), .raddr(iaddr), .rdata(img_rdata)
  );

  conv_bank_ram #(.DEPTH(L0_DEPTH), .AW(AW), .DW(DW)) u_layer0 (
    .clk(clk), .we(cwr && !csel), .waddr(caddr_wr), .wdata(cdata_wr),
    .re(l0_re), .raddr(l0_raddr), .rdata(l0_rdata)
  );

  conv_bank_ram #(.DEPTH(L1_DEPTH), .AW(AW), .DW(DW)) u_layer1 (
    .clk(clk), .we(cwr && csel), .waddr(caddr_wr), .wdata(cdata_wr),
    .re(l1_re), .raddr(l1_raddr), .rdata(l1_rdata)
  );

  // Read-side bookkeeping: which reader owns this cycle's RAM output, plus
  // hold copies so each output keeps its last value between its own reads.
  logic          run_q, crd_q, crd_sel_q, hrd_q, hrd_sel_q;
  logic [DW-1:0] cdata_hold, hrd_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q      <= 1'b0;
      crd_q      <= 1'b0;
      crd_sel_q  <= 1'b0;
      hrd_q      <= 1'b0;
      hrd_sel_q  <= 1'b0;
      cdata_hold <= '0;
      hrd_hold   <= '0;
    end else begin
      run_q      <= (state == ST_RUN);
      crd_q      <= crd;
      crd_sel_q  <= crd ? csel : crd_sel_q;
      hrd_q      <= hrd_ok;
      hrd_sel_q  <= hrd_ok ? hrd_sel : hrd_sel_q;
      cdata_hold <= cdata_rd;
      hrd_hold   <= hrd_data;
    end
  end

  assign idata    = run_q ? img_rdata : '0;
  assign cdata_rd = crd_q ? (crd_sel_q ? l1_rdata : l0_rdata) : cdata_hold;
  assign hrd_data = hrd_q ? (hrd_sel_q ? l1_rdata : l0_rdata) : hrd_hold;
  assign hrd_vld  = hrd_q;

endmodule

// File: tb/tb_conv_mem_host.sv
// Self-checking bench for conv_mem_host: vector table for the layer ports,
// randomized layer/host traffic against array models, and hand sequences for
// the run handshake, timeout, and mid-run reset.
module tb_conv_mem_host;

  localparam int DW = 13;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ready, busy;
  logic [11:0]   iaddr;
  logic [DW-1:0] idata;
  logic          cwr, crd, csel;
  logic [11:0]   caddr_wr, caddr_rd;
  logic [DW-1:0] cdata_wr, cdata_rd;
  logic          ld_en;
  logic [11:0]   ld_addr;
  logic [DW-1:0] ld_data;
  logic          hrd_en, hrd_sel, hrd_vld;
  logic [11:0]   hrd_addr;
  logic [DW-1:0] hrd_data;
  logic          start, done, timeout;
  logic [1:0]    wr_seen;
  logic [30:0]   run_cycles;

  conv_mem_host #(.DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .hrd_en(hrd_en), .hrd_sel(hrd_sel), .hrd_addr(hrd_addr),
    .hrd_data(hrd_data), .hrd_vld(hrd_vld),
    .start(start), .done(done), .timeout(timeout),
    .wr_seen(wr_seen), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference contents of the two layers.
  logic [DW-1:0] m_l0 [4096];
  logic [DW-1:0] m_l1 [1024];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    busy = 0; iaddr = 0; cwr = 0; crd = 0; csel = 0;
    caddr_wr = 0; caddr_rd = 0; cdata_wr = 0;
    ld_en = 0; ld_addr = 0; ld_data = 0;
    hrd_en = 0; hrd_sel = 0; hrd_addr = 0; start = 0;
  endtask

  function automatic logic [DW-1:0] bank_rd(input logic sel, input logic [11:0] a);
    if (sel) return (a >= 12'd1024) ? '0 : m_l1[a[9:0]];
    return m_l0[a];
  endfunction

  task automatic model_wr(input logic sel, input logic [11:0] a, input logic [DW-1:0] d);
    if (!sel)                m_l0[a] = d;
    else if (a < 12'd1024)   m_l1[a[9:0]] = d;
  endtask

  function automatic logic [11:0] pick_addr();
    int r;
    r = $urandom_range(0, 23);
    return (r < 16) ? 12'(r) : 12'(1020 + r - 16);
  endfunction

  typedef struct {
    logic          cwr;
    logic          csel;
    logic [11:0]   waddr;
    logic [DW-1:0] wdata;
    logic          crd;
    logic [11:0]   raddr;
    logic [DW-1:0] exp_rd;
    logic [1:0]    exp_seen;
  } vec_t;

  vec_t vt [13];

  initial begin
    logic [DW-1:0] exp_rd, exp_hd;
    logic [1:0]    exp_seen;
    logic          exp_vld, saw_done;
    logic [11:0]   a;
    int            tout_at;

    vt[0]  = '{1'b1, 1'b1, 12'd3,    13'h1F00, 1'b0, 12'd0,    13'h0000, 2'b10};
    vt[1]  = '{1'b1, 1'b1, 12'd476,  13'h0555, 1'b0, 12'd0,    13'h0000, 2'b10};
    vt[2]  = '{1'b0, 1'b1, 12'd0,    13'h0000, 1'b1, 12'd3,    13'h1F00, 2'b10};
    vt[3]  = '{1'b1, 1'b1, 12'd1500, 13'h0123, 1'b0, 12'd0,    13'h1F00, 2'b10};
    vt[4]  = '{1'b0, 1'b1, 12'd0,    13'h0000, 1'b1, 12'd1500, 13'h0000, 2'b10};
    vt[5]  = '{1'b0, 1'b1, 12'd0,    13'h0000, 1'b1, 12'd476,  13'h0555, 2'b10};
    vt[6]  = '{1'b1, 1'b0, 12'd7,    13'h0022, 1'b0, 12'd0,    13'h0555, 2'b11};
    vt[7]  = '{1'b1, 1'b0, 12'd7,    13'h0011, 1'b1, 12'd7,    13'h0022, 2'b11};
    vt[8]  = '{1'b0, 1'b0, 12'd0,    13'h0000, 1'b1, 12'd7,    13'h0011, 2'b11};
    vt[9]  = '{1'b0, 1'b0, 12'd0,    13'h0000, 1'b0, 12'd0,    13'h0011, 2'b11};
    vt[10] = '{1'b1, 1'b1, 12'd1023, 13'h1ABC, 1'b0, 12'd0,    13'h0011, 2'b11};
    vt[11] = '{1'b0, 1'b1, 12'd0,    13'h0000, 1'b1, 12'd1023, 13'h1ABC, 2'b11};
    vt[12] = '{1'b0, 1'b1, 12'd0,    13'h0000, 1'b1, 12'd1024, 13'h0000, 2'b11};

    // Reset state.
    idle_inputs();
    reset = 0;
    repeat (3) step();
    check("rst ready", ready, 0);
    check("rst done", done, 0);
    check("rst timeout", timeout, 0);
    check("rst wr_seen", wr_seen, 0);
    check("rst run_cycles", run_cycles, 0);
    check("rst idata", idata, 0);
    check("rst cdata_rd", cdata_rd, 0);
    check("rst hrd_data", hrd_data, 0);
    check("rst hrd_vld", hrd_vld, 0);
    reset = 1;
    step();

    // Layer port vectors.
    for (int i = 0; i < 13; i++) begin
      cwr = vt[i].cwr; csel = vt[i].csel; caddr_wr = vt[i].waddr;
      cdata_wr = vt[i].wdata; crd = vt[i].crd; caddr_rd = vt[i].raddr;
      step();
      check($sformatf("vec%0d cdata_rd", i), cdata_rd, vt[i].exp_rd);
      check($sformatf("vec%0d wr_seen", i), wr_seen, vt[i].exp_seen);
      if (vt[i].cwr) model_wr(vt[i].csel, vt[i].waddr, vt[i].wdata);
    end
    idle_inputs();
    exp_rd = 13'h0000;
    exp_seen = 2'b11;

    // Initialise the random address pool in both layers.
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < 24; r++) begin
        a = (r < 16) ? 12'(r) : 12'(1020 + r - 16);
        cwr = 1; csel = b[0]; caddr_wr = a; cdata_wr = DW'($urandom);
        model_wr(csel, a, cdata_wr);
        step();
      end
    end
    idle_inputs();

    // Randomized layer and host traffic while idle.
    for (int c = 0; c < 200; c++) begin
      cwr = $urandom_range(0, 1); crd = $urandom_range(0, 1);
      csel = $urandom_range(0, 1);
      caddr_wr = pick_addr(); caddr_rd = pick_addr(); cdata_wr = DW'($urandom);
      hrd_en = $urandom_range(0, 1); hrd_sel = $urandom_range(0, 1);
      hrd_addr = pick_addr();
      if (hrd_en && crd) hrd_sel = !csel;
      if (crd) exp_rd = bank_rd(csel, caddr_rd);
      exp_vld = hrd_en;
      exp_hd = bank_rd(hrd_sel, hrd_addr);
      if (cwr) begin
        exp_seen[csel] = 1'b1;
        model_wr(csel, caddr_wr, cdata_wr);
      end
      step();
      check("rnd cdata_rd", cdata_rd, exp_rd);
      check("rnd wr_seen", wr_seen, exp_seen);
      check("rnd hrd_vld", hrd_vld, exp_vld);
      if (exp_vld) check("rnd hrd_data", hrd_data, exp_hd);
    end
    idle_inputs();

    // Image preload and a full run.
    ld_en = 1; ld_addr = 12'd5; ld_data = 13'h0ABC;
    step();
    ld_en = 0; iaddr = 12'd5;
    step();
    check("idle idata", idata, 0);
    start = 1;
    step();
    start = 0;
    check("arm ready", ready, 1);
    check("arm run_cycles", run_cycles, 0);
    check("arm wr_seen cleared", wr_seen, 0);
    step();
    check("arm hold ready", ready, 1);
    check("arm run_cycles 1", run_cycles, 1);
    busy = 1;
    step();
    check("run ready", ready, 0);
    check("run run_cycles", run_cycles, 2);
    iaddr = 12'd5; ld_en = 1; ld_addr = 12'd5; ld_data = 13'h1111;
    hrd_en = 1; start = 1;
    step();
    check("run idata", idata, 13'h0ABC);
    check("run hrd_vld", hrd_vld, 0);
    check("run start ignored", run_cycles, 3);
    ld_en = 0; hrd_en = 0; start = 0;
    busy = 0;
    step();
    check("done pulse", done, 1);
    check("done run_cycles", run_cycles, 4);
    step();
    check("done one cycle", done, 0);
    check("back idle ready", ready, 0);
    check("after run idata", idata, 0);
    step();
    check("after run run_cycles", run_cycles, 4);

    // Host readout of result layers while idle.
    for (int k = 0; k < 4; k++) begin
      hrd_en = 1; hrd_sel = k[0]; hrd_addr = (k < 2) ? 12'd7 : 12'd1021;
      exp_hd = bank_rd(hrd_sel, hrd_addr);
      step();
      check("host vld", hrd_vld, 1);
      check("host data", hrd_data, exp_hd);
    end
    idle_inputs();

    // Timeout with busy stuck high.
    busy = 1; start = 1;
    step();
    start = 0;
    saw_done = 0; tout_at = 0;
    for (int n = 1; n <= 60; n++) begin
      step();
      if (done) saw_done = 1;
      if (timeout) begin
        tout_at = n;
        break;
      end
    end
    check("tout cycle", tout_at, 50);
    check("tout no done", saw_done, 0);
    check("tout ready", ready, 0);
    check("tout run_cycles", run_cycles, 50);
    step();
    check("tout sticky", timeout, 1);
    check("tout done", done, 0);
    busy = 0; start = 1;
    step();
    start = 0;
    check("rearm ready", ready, 1);
    check("rearm timeout", timeout, 0);
    check("rearm run_cycles", run_cycles, 0);

    // Reset during RUN.
    busy = 1;
    step();
    step();
    check("pre-reset ready", ready, 0);
    busy = 0;
    #2 reset = 0;
    #1;
    check("mid reset ready", ready, 0);
    check("mid reset done", done, 0);
    check("mid reset run_cycles", run_cycles, 0);
    #2 reset = 1;
    saw_done = 0;
    for (int n = 0; n < 5; n++) begin
      step();
      if (done || ready) saw_done = 1;
    end
    check("post reset idle", saw_done, 0);
    for (int k = 0; k < 2; k++) begin
      hrd_en = 1; hrd_sel = k[0]; hrd_addr = 12'd3;
      exp_hd = bank_rd(hrd_sel, hrd_addr);
      step();
      check("retained host vld", hrd_vld, 1);
      check("retained host data", hrd_data, exp_hd);
    end
    idle_inputs();

    // Image survives reset, and the in-run preload attempt was ignored.
    start = 1;
    step();
    start = 0; busy = 1;
    step();
    iaddr = 12'd5;
    step();
    check("retained idata", idata, 13'h0ABC);
    busy = 0;
    step();
    check("second done", done, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
